// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin write arbiter: shares one FIFO write port among NUM_REQ producers.
// A producer owns the port for a burst of up to BURST_MAX words. A burst only
// starts when the FIFO can absorb all of it, so a stalled owner cannot block
// the other producers for long.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no owner; pick the next requester in rotation if a full burst fits
// BUSY  | owner writes one word per cycle while its req is high and FIFO not full
module fifo_wr_arbiter_rr #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic [ADDR_WIDTH-1:0]         fifo_depth,
  output logic                          fifo_wait
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [ADDR_WIDTH:0] CAP       = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] BURST_LIM = BURST_MAX[ADDR_WIDTH:0];
  localparam logic [BW-1:0]       LAST_CNT  = BW'(BURST_MAX - 1);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]       LAST_INIT = OW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       last_owner;
  logic [BW-1:0]       burst_cnt;

  logic [ADDR_WIDTH:0] free;
  logic                start_ok;
  logic [OW-1:0]       pick;
  logic                pick_valid;
  logic                owner_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                wr;

  // Free space in the FIFO; depth aliases to 0 when full, so full/empty decide the ends.
  always_comb begin
    if (fifo_empty)
      free = CAP;
    else if (fifo_full)
      free = '0;
    else
      free = CAP - {1'b0, fifo_depth};
  end

  assign start_ok = (free >= BURST_LIM);

  // Next owner: first requester after last_owner, wrapping; the smallest distance wins.
  always_comb begin
    pick       = last_owner;
    pick_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NUM_REQ]) begin
        pick       = OW'((int'(last_owner) + k) % NUM_REQ);
        pick_valid = 1'b1;
      end
    end
  end

  // Select the current owner's request and data word.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write only in BUSY; the current full flag alone decides, so full never sees a write.
  assign wr           = (state == BUSY) && owner_req && !fifo_full;
  assign fifo_wen     = wr;
  assign ack          = wr ? gnt : '0;
  assign fifo_data_in = owner_data;
  assign fifo_wait    = (state == BUSY) && owner_req && fifo_full;

  // Arbitration FSM; gnt is registered so there is no req-to-gnt combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_INIT;
      burst_cnt  <= '0;
      gnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && start_ok) begin
            owner     <= pick;
            burst_cnt <= '0;
            gnt       <= ONE_HOT0 << pick;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            // Owner ran dry: release early without writing this cycle.
            last_owner <= owner;
            gnt        <= '0;
            state      <= IDLE;
          end else if (wr) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == LAST_CNT) begin
              last_owner <= owner;
              gnt        <= '0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// Directed bench for fifo_wr_arbiter_rr with a behavioural 16-entry FIFO and
// counting producers; expected grant/write patterns are hand-computed tables.
module tb_fifo_wr_arbiter_rr;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     gnt;
  logic              fifo_wen;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW-1:0]     fifo_depth;
  logic              fifo_wait;

  int n_vec  = 0;
  int n_miss = 0;

  int          rem [NR];
  logic [15:0] val [NR];
  logic [15:0] mem [16];
  logic [4:0]  wp, rp;
  logic        rd_en;
  logic [15:0] rdata;
  logic        rvalid;
  logic [15:0] rq [$];

  // Hand-computed tables, index = cycle after the request appears
  int t1_gnt [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int t1_wen [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int t1_dat [10] = '{0, 'h10, 'h11, 'h12, 'h13, 0, 'h14, 'h15, 0, 0};
  int t3_gnt [11] = '{0, 4, 4, 4, 0, 8, 8, 8, 8, 0, 1};
  int t3_wen [11] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1};
  int t3_dat [11] = '{0, 'h300, 'h301, 0, 0, 'h400, 'h401, 'h402, 'h403, 0, 'h100};

  fifo_wr_arbiter_rr #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .gnt(gnt), .fifo_wen(fifo_wen), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_depth(fifo_depth),
    .fifo_wait(fifo_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*DW +: DW] = val[i];
    end
    fifo_full  = ((wp - rp) == 5'd16);
    fifo_empty = (wp == rp);
    fifo_depth = 4'(wp - rp);
  endtask

  // One clock: sample pre-edge, update producers and FIFO model after the edge.
  task automatic step();
    logic [NR-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    a = ack;
    w = fifo_wen;
    d = fifo_data_in;
    r = rd_en && !fifo_empty;
    chk("wen_while_full", 32'(w & fifo_full), 0);
    chk("ack_not_owner", 32'(ack & ~gnt), 0);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (a[i]) begin
        val[i] = val[i] + 16'd1;
        rem[i] = rem[i] - 1;
      end
    end
    if (w) begin
      mem[wp[3:0]] = d;
      wp = wp + 5'd1;
    end
    if (r) begin
      rdata = mem[rp[3:0]];
      rp = rp + 5'd1;
      rvalid = 1'b1;
      rq.push_back(rdata);
    end
    drive();
    #1;
  endtask

  task automatic load(input int i, input int n, input logic [15:0] base);
    rem[i] = n;
    val[i] = base;
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      val[i] = '0;
    end
    wp = '0;
    rp = '0;
    rq.delete();
    drive();
    #1;
    chk("rst gnt", 32'(gnt), 0);
    chk("rst ack", 32'(ack), 0);
    chk("rst wen", 32'(fifo_wen), 0);
    chk("rst wait", 32'(fifo_wait), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
    #1;
  endtask

  task automatic drain_check(input string tag, input logic [15:0] exp[$]);
    int guard = 0;
    rd_en = 1'b1;
    while (!fifo_empty && guard < 40) begin
      step();
      guard++;
    end
    rd_en = 1'b0;
    chk({tag, " count"}, 32'(rq.size()), 32'(exp.size()));
    foreach (exp[k])
      if (k < rq.size())
        chk($sformatf("%s word%0d", tag, k), 32'(rq[k]), 32'(exp[k]));
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e [$];

    // Single requester: 4 + 2 words with one IDLE cycle between bursts
    do_reset();
    load(0, 6, 16'h0010);
    chk("t1 c0 gnt", 32'(gnt), 0);
    chk("t1 c0 wen", 32'(fifo_wen), 0);
    for (int c = 1; c <= 9; c++) begin
      step();
      chk($sformatf("t1 c%0d gnt", c), 32'(gnt), t1_gnt[c]);
      chk($sformatf("t1 c%0d wen", c), 32'(fifo_wen), t1_wen[c]);
      if (t1_wen[c] != 0)
        chk($sformatf("t1 c%0d data", c), 32'(fifo_data_in), t1_dat[c]);
    end
    e = {16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
    drain_check("t1 fifo", e);

    // Four requesters continuously: grant order 0,1,2,3,0 with reads running
    do_reset();
    load(0, 8, 16'h0100);
    load(1, 4, 16'h0200);
    load(2, 4, 16'h0300);
    load(3, 4, 16'h0400);
    rd_en = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      chk($sformatf("t2 c%0d gnt", c), 32'(gnt),
          (c % 5 == 0) ? 0 : (1 << ((c / 5) % 4)));
      chk($sformatf("t2 c%0d wen", c), 32'(fifo_wen), (c % 5 == 0) ? 0 : 1);
    end
    e = {16'h0100, 16'h0101, 16'h0102, 16'h0103,
         16'h0200, 16'h0201, 16'h0202, 16'h0203,
         16'h0300, 16'h0301, 16'h0302, 16'h0303,
         16'h0400, 16'h0401, 16'h0402, 16'h0403,
         16'h0104, 16'h0105, 16'h0106, 16'h0107};
    drain_check("t2 fifo", e);

    // Early release of requester 2: next grant goes to 3, then 0
    do_reset();
    load(2, 2, 16'h0300);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        load(0, 4, 16'h0100);
        load(3, 4, 16'h0400);
      end
      chk($sformatf("t3 c%0d gnt", c), 32'(gnt), t3_gnt[c]);
      chk($sformatf("t3 c%0d wen", c), 32'(fifo_wen), t3_wen[c]);
      if (t3_wen[c] != 0)
        chk($sformatf("t3 c%0d data", c), 32'(fifo_data_in), t3_dat[c]);
    end
    e = {16'h0300, 16'h0301, 16'h0400, 16'h0401, 16'h0402, 16'h0403,
         16'h0100, 16'h0101, 16'h0102, 16'h0103};
    drain_check("t3 fifo", e);

    // Full stall mid-burst for owner 1; the FIFO is topped up behind its back
    do_reset();
    for (int k = 0; k < 12; k++) mem[k] = 16'hEE00 + 16'(k);
    wp = 5'd12;
    load(1, 8, 16'h0500);
    chk("t4 c0 gnt", 32'(gnt), 0);
    step();
    chk("t4 c1 gnt", 32'(gnt), 2);
    chk("t4 c1 data", 32'(fifo_data_in), 'h500);
    step();
    chk("t4 c2 wen", 32'(fifo_wen), 1);
    step();
    mem[wp[3:0]] = 16'hEEEE; wp = wp + 5'd1;
    mem[wp[3:0]] = 16'hEEEE; wp = wp + 5'd1;
    drive();
    #1;
    chk("t4 c3 wait", 32'(fifo_wait), 1);
    chk("t4 c3 wen", 32'(fifo_wen), 0);
    chk("t4 c3 ack", 32'(ack), 0);
    chk("t4 c3 gnt", 32'(gnt), 2);
    step();
    rd_en = 1'b1;
    chk("t4 c4 wen during read", 32'(fifo_wen), 0);
    chk("t4 c4 wait", 32'(fifo_wait), 1);
    step();
    rd_en = 1'b0;
    chk("t4 c5 wen", 32'(fifo_wen), 1);
    chk("t4 c5 data", 32'(fifo_data_in), 'h502);
    chk("t4 c5 wait", 32'(fifo_wait), 0);
    chk("t4 c5 ack", 32'(ack), 2);
    step();
    chk("t4 c6 wait", 32'(fifo_wait), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4 c7 wen", 32'(fifo_wen), 1);
    chk("t4 c7 data", 32'(fifo_data_in), 'h503);
    step();
    chk("t4 c8 gnt", 32'(gnt), 0);
    chk("t4 c8 wait", 32'(fifo_wait), 0);
    step();
    chk("t4 c9 gnt", 32'(gnt), 0);
    chk("t4 reads", 32'(rq.size()), 2);

    // Space gating: depth 13 blocks a new burst until one word is read
    do_reset();
    wp = 5'd13;
    load(0, 4, 16'h0600);
    step();
    chk("t5 c1 gnt", 32'(gnt), 0);
    chk("t5 c1 wen", 32'(fifo_wen), 0);
    step();
    chk("t5 c2 gnt", 32'(gnt), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5 c3 gnt", 32'(gnt), 0);
    step();
    chk("t5 c4 gnt", 32'(gnt), 1);
    chk("t5 c4 wen", 32'(fifo_wen), 1);
    chk("t5 c4 data", 32'(fifo_data_in), 'h600);

    // Reset during a burst of requester 3; requester 0 wins afterwards
    do_reset();
    load(3, 8, 16'h0700);
    step();
    chk("t6 c1 gnt", 32'(gnt), 8);
    chk("t6 c1 data", 32'(fifo_data_in), 'h700);
    step();
    chk("t6 c2 wen", 32'(fifo_wen), 1);
    reset = 1'b1;
    #1;
    chk("t6 rst gnt", 32'(gnt), 0);
    chk("t6 rst ack", 32'(ack), 0);
    chk("t6 rst wen", 32'(fifo_wen), 0);
    chk("t6 rst wait", 32'(fifo_wait), 0);
    load(0, 4, 16'h0800);
    step();
    reset = 1'b0;
    drive();
    #1;
    chk("t6 idle gnt", 32'(gnt), 0);
    step();
    chk("t6 after gnt", 32'(gnt), 1);
    chk("t6 after data", 32'(fifo_data_in), 'h800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
